uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the mother board: the transmit-side counterpart to the board's `uart_rx` path. It accepts bytes from the CPU bus side through a valid/ready handshake, queues them in a small FIFO and serialises them onto `uart_tx` as 8N1 frames (start bit, 8 data bits LSB first, stop bit). Each bit lasts `WAIT` clock cycles, the same bit-period convention the receiver uses.

---
 rtl/uart_tx_fifo_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte write handshake between a producer and the UART transmit FIFO.
interface uart_tx_fifo_if;
  logic [7:0] w_data;
  logic       w_valid;
  logic       w_ready;

  modport master (output w_data, output w_valid, input w_ready);
  modport slave  (input w_data, input w_valid, output w_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO feeding an 8N1 serialiser, WAIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int WAIT  = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_fifo_if.slave          wr,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  // state    | meaning
  // S_IDLE   | line high, waiting for a queued byte
  // S_START  | start bit (low)
  // S_DATA   | eight data bits, LSB first
  // S_PARITY | even-parity bit (UART_TX_PARITY_EN only)
  // S_STOP   | stop bit (high); may pop the next byte straight into S_START

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(WAIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic ready;
  logic push;
  logic pop;
  logic bit_end;

  assign ready      = (count_q != FULL);
  assign wr.w_ready = ready;
  assign uart_tx    = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    push     = wr.w_valid && ready;
    bit_end  = (baud_q == BAUD_LAST);
    pop      = 1'b0;
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + BW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // A waiting byte starts its frame with no idle gap
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    if (push) begin
      mem_d[wr_ptr_q] = wr.w_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // Line level follows the state being entered so uart_tx stays a pure flop
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame tables, burst/reset/WAIT=1 sequences, random traffic vs a line decoder.
module tb_uart_tx_fifo;
  localparam int W = 8;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_if ifc8 ();
  uart_tx_fifo_if ifc1 ();

  logic       tx8, busy8, tx1, busy1;
  logic [2:0] cnt8, cnt1;

  uart_tx_fifo #(.WAIT(W), .DEPTH(D)) dut8 (
    .clk(clk), .reset(reset), .wr(ifc8),
    .uart_tx(tx8), .busy(busy8), .fifo_count(cnt8)
  );

  uart_tx_fifo #(.WAIT(1), .DEPTH(D)) dut1 (
    .clk(clk), .reset(reset), .wr(ifc1),
    .uart_tx(tx1), .busy(busy1), .fifo_count(cnt1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // frame f packed {stop, data[7:0], start}; k is the line position of the bit
  function automatic logic fbit(input logic [9:0] f, input logic par, input int k);
`ifdef UART_TX_PARITY_EN
    if (k == 9)  return par;
    if (k == 10) return f[9];
`endif
    if (par === 1'bx) return 1'bx;
    return f[k];
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  // recorded traces of dut8, one entry per falling edge
  bit         tr_line [$];
  bit         tr_busy [$];
  bit         tr_rdy  [$];
  int         tr_cnt  [$];
  int         push_at [$];
  logic [7:0] exp_q   [$];

  task automatic clr();
    tr_line.delete(); tr_busy.delete(); tr_rdy.delete(); tr_cnt.delete();
    push_at.delete(); exp_q.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    tr_line.push_back(tx8);
    tr_busy.push_back(busy8);
    tr_rdy.push_back(ifc8.w_ready);
    tr_cnt.push_back(int'(cnt8));
  endtask

  // Decode the recorded line into frames and compare against pushed bytes and queue occupancy
  task automatic analyse(input bit contig);
    int         p, errs, cerr, berr, rerr, np, ns, ec;
    bit         infr;
    logic [10:0] bits;
    int         starts [$];
    logic [7:0] got [$];
    p = 0;
    while (p < tr_line.size()) begin
      if (tr_line[p]) begin
        p++;
      end else begin
        if (p + FL > tr_line.size()) begin
          chk("frame_truncated", tr_line.size() - p, FL);
          break;
        end
        bits = '0;
        errs = 0;
        for (int k = 0; k < NB; k++) begin
          bits[k] = tr_line[p + k*W];
          for (int j = 0; j < W; j++)
            if (tr_line[p + k*W + j] != bits[k]) errs++;
        end
        chk("bit_width_errs", errs, 0);
        chk("start_bit", int'(bits[0]), 0);
        chk("stop_bit", int'(bits[NB-1]), 1);
`ifdef UART_TX_PARITY_EN
        chk("parity_bit", int'(bits[9]), int'(^bits[8:1]));
`endif
        got.push_back(bits[8:1]);
        starts.push_back(p);
        p += FL;
      end
    end
    chk("frames_seen", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("byte_order[%0d]", i), int'(got[i]), int'(exp_q[i]));
    if (contig)
      for (int k = 1; k < starts.size(); k++)
        chk("contiguous_gap", starts[k] - starts[k-1], FL);
    cerr = 0; berr = 0; rerr = 0;
    for (int s = 0; s < tr_line.size(); s++) begin
      np = 0; ns = 0; infr = 1'b0;
      foreach (push_at[i]) if (push_at[i] <= s) np++;
      foreach (starts[i]) begin
        if (starts[i] <= s) ns++;
        if (s >= starts[i] && s < starts[i] + FL) infr = 1'b1;
      end
      ec = np - ns;
      if (tr_cnt[s] != ec) cerr++;
      if (tr_busy[s] != ((ec != 0) || infr)) berr++;
      if (tr_rdy[s] != (ec != D)) rerr++;
    end
    chk("count_trace_errs", cerr, 0);
    chk("busy_trace_errs", berr, 0);
    chk("ready_trace_errs", rerr, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int   errs, n, pct;
    logic e;
    logic [9:0] pat;

    vecs[0] = '{8'h0F, 10'b1_0000_1111_0, 1'b0};
    vecs[1] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
    vecs[2] = '{8'h55, 10'b1_0101_0101_0, 1'b0};
    vecs[3] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
    vecs[4] = '{8'h80, 10'b1_1000_0000_0, 1'b1};
    vecs[5] = '{8'hFE, 10'b1_1111_1110_0, 1'b1};

    reset = 1'b0;
    ifc8.w_valid = 1'b0; ifc8.w_data = '0;
    ifc1.w_valid = 1'b0; ifc1.w_data = '0;
    #23;
    chk("rst_tx", tx8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_count", int'(cnt8), 0);
    chk("rst_ready", ifc8.w_ready, 1);
    chk("rst_tx_w1", tx1, 1);
    chk("rst_busy_w1", busy1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // table: single byte frames from IDLE
    foreach (vecs[v]) begin
      chk("ready_before_push", ifc8.w_ready, 1);
      ifc8.w_data = vecs[v].data;
      ifc8.w_valid = 1'b1;
      @(negedge clk);
      ifc8.w_valid = 1'b0;
      chk("count_after_push", int'(cnt8), 1);
      chk("tx_idle_at_push", tx8, 1);
      chk("busy_at_push", busy8, 1);
      @(negedge clk);
      chk("count_after_pop", int'(cnt8), 0);
      for (int k = 0; k < NB; k++) begin
        errs = 0;
        e = fbit(vecs[v].frame, vecs[v].par, k);
        for (int j = 0; j < W; j++) begin
          if (tx8 != e) errs++;
          if (k == NB-1 && j == W-1) chk("busy_last_stop", busy8, 1);
          @(negedge clk);
        end
        chk($sformatf("vec%0d_bit%0d_errs", v, k), errs, 0);
      end
      chk("busy_after_frame", busy8, 0);
      chk("tx_after_frame", tx8, 1);
      @(negedge clk);
    end

    // burst of six bytes with w_valid held high; sixth must stall on a full FIFO
    clr();
    tick();
    for (int i = 0; i < 6; i++) begin
      ifc8.w_data  = 8'(i + 1);
      ifc8.w_valid = 1'b1;
      n = 0;
      while (!ifc8.w_ready && n < 4*FL) begin
        tick();
        n++;
      end
      if (i == 5) begin
        chk("burst_stalled", int'(n > 0), 1);
        chk("ready_rise_count", int'(cnt8), D-1);
      end
      chk("burst_accept_timeout", int'(ifc8.w_ready), 1);
      push_at.push_back(tr_line.size());
      exp_q.push_back(ifc8.w_data);
      tick();
      if (i == 4) begin
        chk("burst_full_count", int'(cnt8), D);
        chk("burst_full_ready", ifc8.w_ready, 0);
      end
    end
    ifc8.w_valid = 1'b0;
    n = 0;
    while (busy8 && n < 8*FL) begin tick(); n++; end
    chk("burst_drain", busy8, 0);
    tick();
    analyse(1'b1);

    // random traffic, sparse then dense
    clr();
    tick();
    for (int c = 0; c < 1600; c++) begin
      pct = (c < 800) ? 2 : 40;
      ifc8.w_valid = ($urandom_range(0, 99) < pct);
      ifc8.w_data  = 8'($urandom);
      if (ifc8.w_valid && ifc8.w_ready) begin
        push_at.push_back(tr_line.size());
        exp_q.push_back(ifc8.w_data);
      end
      tick();
    end
    ifc8.w_valid = 1'b0;
    n = 0;
    while (busy8 && n < (D+2)*FL) begin tick(); n++; end
    chk("random_drain", busy8, 0);
    tick();
    analyse(1'b0);

    // reset during data bit 3 of 0x55 with two bytes queued
    ifc8.w_data = 8'h55; ifc8.w_valid = 1'b1;
    @(negedge clk); ifc8.w_data = 8'h66;
    @(negedge clk); ifc8.w_data = 8'h77;
    @(negedge clk); ifc8.w_valid = 1'b0;
    repeat (4*W + W/2 - 1) @(negedge clk);
    chk("pre_reset_tx_bit3", tx8, 0);
    chk("pre_reset_count", int'(cnt8), 2);
    #1 reset = 1'b0;
    #1;
    chk("mid_reset_tx", tx8, 1);
    chk("mid_reset_count", int'(cnt8), 0);
    chk("mid_reset_busy", busy8, 0);
    chk("mid_reset_ready", ifc8.w_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    errs = 0;
    for (int c = 0; c < 3*FL; c++) begin
      @(negedge clk);
      if (tx8 != 1'b1 || busy8 != 1'b0) errs++;
    end
    chk("post_reset_quiet_errs", errs, 0);

    // WAIT=1: single byte, then two back-to-back frames
    pat = 10'b1_1010_0101_0;
    ifc1.w_data = 8'hA5; ifc1.w_valid = 1'b1;
    @(negedge clk);
    ifc1.w_valid = 1'b0;
    chk("w1_count_after_push", int'(cnt1), 1);
    chk("w1_tx_at_push", tx1, 1);
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("w1_bit%0d", k), tx1, fbit(pat, 1'b0, k));
      @(negedge clk);
    end
    chk("w1_busy_after", busy1, 0);
    chk("w1_tx_after", tx1, 1);

    ifc1.w_data = 8'h3C; ifc1.w_valid = 1'b1;
    @(negedge clk);
    ifc1.w_data = 8'hC3;
    @(negedge clk);
    ifc1.w_valid = 1'b0;
    errs = 0;
    for (int k = 0; k < 2*NB; k++) begin
      e = (k < NB) ? fbit(10'b1_0011_1100_0, 1'b0, k) : fbit(10'b1_1100_0011_0, 1'b0, k - NB);
      if (tx1 != e) errs++;
      @(negedge clk);
    end
    chk("w1_b2b_errs", errs, 0);
    chk("w1_b2b_busy_after", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
